// File: rtl/multicycle_control_unit.sv
// Multicycle FSM control unit: sequences IF/ID/EX/MEM/WB/HALT and decodes datapath controls.
// Latency: controls are combinational from state+instr; 2-5 cycles per instruction plus memory waits.
// Backpressure: IF and MEM hold, with requests asserted, until mem_ready is seen high.
module multicycle_control_unit #(
    parameter int WORD_SIZE = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] instr,
    input  logic                 mem_ready,
    output logic                 i_or_d,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_write_cond,
    output logic [1:0]           pc_source,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [2:0]           alu_op,
    output logic                 reg_write,
    output logic                 mem_to_reg,
    output logic                 pc_to_reg,
    output logic                 wwd,
    output logic                 is_halted,
    output logic [CNT_WIDTH-1:0] num_inst,
    output logic [2:0]           state
);

    localparam logic [2:0] S_IF   = 3'd0;
    localparam logic [2:0] S_ID   = 3'd1;
    localparam logic [2:0] S_EX   = 3'd2;
    localparam logic [2:0] S_MEM  = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;
    localparam logic [2:0] S_HALT = 3'd5;

    localparam logic [3:0] OP_BNE = 4'd0;
    localparam logic [3:0] OP_BEQ = 4'd1;
    localparam logic [3:0] OP_BGZ = 4'd2;
    localparam logic [3:0] OP_BLZ = 4'd3;
    localparam logic [3:0] OP_ADI = 4'd4;
    localparam logic [3:0] OP_ORI = 4'd5;
    localparam logic [3:0] OP_LHI = 4'd6;
    localparam logic [3:0] OP_LWD = 4'd7;
    localparam logic [3:0] OP_SWD = 4'd8;
    localparam logic [3:0] OP_JMP = 4'd9;
    localparam logic [3:0] OP_JAL = 4'd10;
    localparam logic [3:0] OP_R   = 4'd15;

    localparam logic [5:0] FN_JPR = 6'd25;
    localparam logic [5:0] FN_JRL = 6'd26;
    localparam logic [5:0] FN_WWD = 6'd28;
    localparam logic [5:0] FN_HLT = 6'd29;

    localparam logic [2:0] FUNC_ADD = 3'd0;
    localparam logic [2:0] FUNC_SUB = 3'd1;
    localparam logic [2:0] FUNC_ORR = 3'd3;
    localparam logic [2:0] FUNC_SHL = 3'd6;

    localparam logic [1:0] PC_NEXT = 2'd0;
    localparam logic [1:0] PC_BR   = 2'd1;
    localparam logic [1:0] PC_JUMP = 2'd2;
    localparam logic [1:0] PC_REG  = 2'd3;

    localparam logic [1:0] SRCB_RT   = 2'd0;
    localparam logic [1:0] SRCB_ONE  = 2'd1;
    localparam logic [1:0] SRCB_SEXT = 2'd2;
    localparam logic [1:0] SRCB_ZEXT = 2'd3;

    typedef struct packed {
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       reg_write;
        logic       mem_to_reg;
        logic       pc_to_reg;
        logic       wwd;
        logic       is_halted;
    } ctrl_t;

    logic [2:0]           state_q;
    logic [2:0]           state_d;
    logic [CNT_WIDTH-1:0] num_inst_q;
    logic                 count_en;
    ctrl_t                ctrl;
    ctrl_t                ctrl_out;

    logic [3:0] opcode;
    logic [5:0] func;
    logic       unused_instr_bits;

    assign opcode            = instr[WORD_SIZE-1 -: 4];
    assign func              = instr[5:0];
    assign unused_instr_bits = ^instr[WORD_SIZE-5:6];

    logic is_rtype, is_r_alu, is_jmp, is_jal, is_jpr, is_jrl, is_wwd, is_hlt;
    logic is_adi, is_ori, is_lhi, is_lwd, is_swd, is_branch, goes_to_ex;

    assign is_rtype   = (opcode == OP_R);
    assign is_r_alu   = is_rtype && (func[5:3] == 3'b000);
    assign is_jpr     = is_rtype && (func == FN_JPR);
    assign is_jrl     = is_rtype && (func == FN_JRL);
    assign is_wwd     = is_rtype && (func == FN_WWD);
    assign is_hlt     = is_rtype && (func == FN_HLT);
    assign is_jmp     = (opcode == OP_JMP);
    assign is_jal     = (opcode == OP_JAL);
    assign is_adi     = (opcode == OP_ADI);
    assign is_ori     = (opcode == OP_ORI);
    assign is_lhi     = (opcode == OP_LHI);
    assign is_lwd     = (opcode == OP_LWD);
    assign is_swd     = (opcode == OP_SWD);
    assign is_branch  = (opcode == OP_BNE) || (opcode == OP_BEQ) ||
                        (opcode == OP_BGZ) || (opcode == OP_BLZ);
    assign goes_to_ex = is_r_alu || is_adi || is_ori || is_lhi ||
                        is_lwd || is_swd || is_branch;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF:   state_d = mem_ready ? S_ID : S_IF;
            S_ID: begin
                if (is_hlt)          state_d = S_HALT;
                else if (goes_to_ex) state_d = S_EX;
                else                 state_d = S_IF;
            end
            S_EX: begin
                if (is_lwd || is_swd)                         state_d = S_MEM;
                else if (is_r_alu || is_adi || is_ori || is_lhi) state_d = S_WB;
                else                                          state_d = S_IF;
            end
            S_MEM: begin
                if (!mem_ready)  state_d = S_MEM;
                else if (is_lwd) state_d = S_WB;
                else             state_d = S_IF;
            end
            S_WB:   state_d = S_IF;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    // An instruction retires on its last cycle; codes 6-7 recovering to IF do not retire anything.
    assign count_en = ((state_d == S_IF) &&
                       ((state_q == S_ID) || (state_q == S_EX) ||
                        (state_q == S_MEM) || (state_q == S_WB))) ||
                      ((state_q == S_ID) && (state_d == S_HALT));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            num_inst_q <= '0;
        end else if (count_en) begin
            num_inst_q <= num_inst_q + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        ctrl = '0;
        case (state_q)
            S_IF: begin
                ctrl.mem_read = 1'b1;
                if (mem_ready) begin
                    ctrl.ir_write  = 1'b1;
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PC_NEXT;
                    ctrl.alu_src_a = 1'b0;
                    ctrl.alu_src_b = SRCB_ONE;
                    ctrl.alu_op    = FUNC_ADD;
                end
            end
            S_ID: begin
                if (is_jmp || is_jal) begin
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PC_JUMP;
                end
                if (is_jpr || is_jrl) begin
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PC_REG;
                end
                if (is_jal || is_jrl) begin
                    ctrl.reg_write = 1'b1;
                    ctrl.pc_to_reg = 1'b1;
                end
                ctrl.wwd = is_wwd;
            end
            S_EX: begin
                ctrl.alu_src_a = 1'b1;
                if (is_r_alu) begin
                    // R-type func codes 0-7 share their encoding with the ALU op codes.
                    ctrl.alu_src_b = SRCB_RT;
                    ctrl.alu_op    = func[2:0];
                end else if (is_adi || is_lwd || is_swd) begin
                    ctrl.alu_src_b = SRCB_SEXT;
                    ctrl.alu_op    = FUNC_ADD;
                end else if (is_ori) begin
                    ctrl.alu_src_b = SRCB_ZEXT;
                    ctrl.alu_op    = FUNC_ORR;
                end else if (is_lhi) begin
                    ctrl.alu_src_b = SRCB_ZEXT;
                    ctrl.alu_op    = FUNC_SHL;
                end else if (is_branch) begin
                    ctrl.alu_src_b     = SRCB_RT;
                    ctrl.alu_op        = FUNC_SUB;
                    ctrl.pc_write_cond = 1'b1;
                    ctrl.pc_source     = PC_BR;
                end else begin
                    ctrl.alu_src_a = 1'b0;
                end
            end
            S_MEM: begin
                ctrl.i_or_d    = 1'b1;
                ctrl.mem_read  = is_lwd;
                ctrl.mem_write = is_swd;
            end
            S_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = is_lwd;
            end
            S_HALT: ctrl.is_halted = 1'b1;
            default: ;
        endcase
    end

    // Reset must silence every control at once, not at the next edge.
    assign ctrl_out = reset_n ? ctrl : '0;

    assign i_or_d        = ctrl_out.i_or_d;
    assign mem_read      = ctrl_out.mem_read;
    assign mem_write     = ctrl_out.mem_write;
    assign ir_write      = ctrl_out.ir_write;
    assign pc_write      = ctrl_out.pc_write;
    assign pc_write_cond = ctrl_out.pc_write_cond;
    assign pc_source     = ctrl_out.pc_source;
    assign alu_src_a     = ctrl_out.alu_src_a;
    assign alu_src_b     = ctrl_out.alu_src_b;
    assign alu_op        = ctrl_out.alu_op;
    assign reg_write     = ctrl_out.reg_write;
    assign mem_to_reg    = ctrl_out.mem_to_reg;
    assign pc_to_reg     = ctrl_out.pc_to_reg;
    assign wwd           = ctrl_out.wwd;
    assign is_halted     = ctrl_out.is_halted;
    assign num_inst      = num_inst_q;
    assign state         = state_q;

endmodule
